// File: rtl/gb_bus_arbiter.sv
// gb_bus_arbiter: single-owner bus arbiter in front of gb_memory_controller.
//
// Four requesters share one memory bus: port 0 UART ROM loader, port 1 GDMA, port 2 OAM DMA,
// port 3 CPU. Fixed priority 0 > 1 > 2 > 3 with preemption, one dead TURN cycle between owners
// and a CPU starvation guard that forces a one-cycle CPU slot after STARVE_MAX waiting cycles.
//
// Ports:
//   clock_i, rst_ni          clock, asynchronous active-low reset
//   req_i, lock_i            per-port request / burst lock
//   p_addr_i, p_wdata_i      per-port address / write data, port 0 in the LSBs
//   p_we_i, p_re_i           per-port write / read strobes
//   gnt_o                    one-hot grant (zero in IDLE/TURN)
//   rd_valid_o, rdata_o      registered read return, one cycle after a granted read
//   mem_addr_o, mem_wdata_o  memory-controller bus (address holds while unowned)
//   mem_we_o, mem_re_o       memory-controller strobes, owner only
//   mem_rdata_i              memory-controller read data
//   owner_o, busy_o          current owner id (valid when busy) / bus owned
//
// Optional build macro GB_ARB_STATS_EN adds stall_clr_i and stall_cnt_o: a saturating count of
// cycles where the CPU requests but is not granted.

module gb_bus_arbiter #(
  parameter logic [7:0]  STARVE_MAX = 8'd64,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                clock_i,
  input  logic                rst_ni,
  input  logic [3:0]          req_i,
  input  logic [3:0]          lock_i,
  input  logic [4*ADDR_W-1:0] p_addr_i,
  input  logic [4*DATA_W-1:0] p_wdata_i,
  input  logic [3:0]          p_we_i,
  input  logic [3:0]          p_re_i,
  output logic [3:0]          gnt_o,
  output logic [3:0]          rd_valid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic                mem_we_o,
  output logic                mem_re_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [1:0]          owner_o,
`ifdef GB_ARB_STATS_EN
  input  logic                stall_clr_i,
  output logic [15:0]         stall_cnt_o,
`endif
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              force_q, force_d;   // next TURN hands the bus to the CPU
  logic              slot_q, slot_d;     // current CPU ownership is a forced one-cycle slot
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [3:0]        rd_valid_q;
  logic [DATA_W-1:0] rdata_q;

  logic              own;
  logic [3:0]        owner_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we, sel_re;
  logic [3:0]        preempt_mask;
  logic              cpu_wait;
  logic [7:0]        starve_inc;
  logic              starve_fire;
  logic              leave;

  function automatic logic [1:0] pick(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign own       = (state_q == StOwn);
  assign owner_oh  = 4'b0001 << owner_q;
  assign sel_addr  = p_addr_i[32'(owner_q) * ADDR_W +: ADDR_W];
  assign sel_wdata = p_wdata_i[32'(owner_q) * DATA_W +: DATA_W];
  assign sel_we    = p_we_i[owner_q];
  assign sel_re    = p_re_i[owner_q];

  assign gnt_o       = own ? owner_oh : 4'b0000;
  assign mem_we_o    = own & sel_we;
  assign mem_re_o    = own & sel_re & ~sel_we;  // write wins over a simultaneous read
  assign mem_addr_o  = own ? sel_addr : mem_addr_q;
  assign mem_wdata_o = own ? sel_wdata : mem_wdata_q;
  assign owner_o     = owner_q;
  assign busy_o      = own;
  assign rd_valid_o  = rd_valid_q;
  assign rdata_o     = rdata_q;

  // Lock-respecting preemptors per owner; GDMA and OAM DMA never preempt each other.
  always_comb begin
    unique case (owner_q)
      2'd0:       preempt_mask = 4'b0000;
      2'd1, 2'd2: preempt_mask = 4'b0001;
      default:    preempt_mask = 4'b0111;
    endcase
  end

  assign cpu_wait    = own & ((owner_q == 2'd1) | (owner_q == 2'd2)) & req_i[3];
  assign starve_inc  = (starve_q == STARVE_MAX) ? starve_q : starve_q + 8'd1;
  assign starve_fire = (STARVE_MAX != 8'd0) & cpu_wait & (starve_inc == STARVE_MAX);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    force_d  = force_q;
    slot_d   = slot_q;
    starve_d = starve_q;
    leave    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StOwn;
          owner_d = pick(req_i);
        end
      end
      StOwn: begin
        if (owner_q == 2'd3)   starve_d = 8'd0;
        else if (cpu_wait)     starve_d = starve_inc;
        // UART preempts everyone regardless of lock.
        leave = ~req_i[owner_q]
              | (req_i[0] & (owner_q != 2'd0))
              | (~lock_i[owner_q] & (|(req_i & preempt_mask)))
              | slot_q
              | starve_fire;
        if (starve_fire) force_d = 1'b1;
        slot_d = 1'b0;
        if (leave) state_d = StTurn;
      end
      StTurn: begin
        force_d = 1'b0;
        if (force_q & req_i[3]) begin
          state_d = StOwn;
          owner_d = 2'd3;
          slot_d  = 1'b1;
        end else if (|req_i) begin
          state_d = StOwn;
          owner_d = pick(req_i);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= 2'd0;
      force_q     <= 1'b0;
      slot_q      <= 1'b0;
      starve_q    <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 4'b0000;
      rdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      force_q    <= force_d;
      slot_q     <= slot_d;
      starve_q   <= starve_d;
      if (own) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      rd_valid_q <= mem_re_o ? owner_oh : 4'b0000;
      if (mem_re_o) rdata_q <= mem_rdata_i;
    end
  end

`ifdef GB_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_clr_i) begin
      stall_cnt_q <= 16'd0;
    end else if (req_i[3] & ~gnt_o[3] & (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gb_bus_arbiter.sv
// Self-checking bench for gb_bus_arbiter: a directed vector table, hand-written multi-cycle
// sequences (read return, starvation slot, async reset, optional stall counter) and a random
// run compared against a cycle-level reference model of the arbitration rules.

module tb_gb_bus_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [7:0]  STARVE = 8'd4;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, lock, we, re;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wd [4];
  logic [DW-1:0] mrd;
  logic sclr;

  logic [4*AW-1:0] p_addr;
  logic [4*DW-1:0] p_wdata;
  logic [3:0] gnt, rd_valid;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic mem_we, mem_re, busy;
  logic [1:0] owner;
`ifdef GB_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  assign p_addr  = {addr[3], addr[2], addr[1], addr[0]};
  assign p_wdata = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  gb_bus_arbiter #(.STARVE_MAX(STARVE), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i    (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .lock_i     (lock),
    .p_addr_i   (p_addr),
    .p_wdata_i  (p_wdata),
    .p_we_i     (we),
    .p_re_i     (re),
    .gnt_o      (gnt),
    .rd_valid_o (rd_valid),
    .rdata_o    (rdata),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_we_o   (mem_we),
    .mem_re_o   (mem_re),
    .mem_rdata_i(mrd),
    .owner_o    (owner),
`ifdef GB_ARB_STATS_EN
    .stall_clr_i(sclr),
    .stall_cnt_o(stall_cnt),
`endif
    .busy_o     (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = unowned), dead-cycle flag, CPU-slot bookkeeping.
  int m_owner, m_wait, m_stall;
  bit m_turn, m_force, m_slot;
  logic [3:0] m_rdv;
  logic [DW-1:0] m_rdata, m_wd_last;
  logic [AW-1:0] m_addr_last;

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_turn = 0; m_force = 0; m_slot = 0; m_wait = 0; m_stall = 0;
    m_rdv = '0; m_rdata = '0; m_wd_last = '0; m_addr_last = '0;
  endtask

  task automatic model_step();
    int o;
    bit leave;
    o = m_owner;
    if (sclr) m_stall = 0;
    else if (req[3] && o != 3 && m_stall < 65535) m_stall++;
    m_rdv = 4'b0000;
    if (o >= 0) begin
      if (re[o] && !we[o]) begin
        m_rdv = 4'b0001 << o;
        m_rdata = mrd;
      end
      m_addr_last = addr[o];
      m_wd_last = wd[o];
      leave = !req[o];
      if (o != 0 && req[0]) leave = 1;
      if (o == 3 && !lock[3] && (req[1] || req[2])) leave = 1;
      if (m_slot) leave = 1;
      if (o == 3) m_wait = 0;
      else if (o != 0 && req[3] && int'(STARVE) > 0) begin
        m_wait++;
        if (m_wait >= int'(STARVE)) begin
          leave = 1;
          m_force = 1;
        end
      end
      m_slot = 0;
      if (leave) begin
        m_owner = -1;
        m_turn = 1;
      end
    end else if (m_turn) begin
      m_turn = 0;
      if (m_force && req[3]) begin
        m_owner = 3;
        m_slot = 1;
      end else if (req != 0) begin
        m_owner = lowest(req);
      end
      m_force = 0;
    end else if (req != 0) begin
      m_owner = lowest(req);
    end
  endtask

  task automatic check_model();
    int o;
    logic [3:0] eg;
    o = (m_owner < 0) ? 0 : m_owner;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << o);
    chk("rnd_gnt", gnt, eg);
    chk("rnd_busy", busy, m_owner >= 0);
    chk("rnd_mem_we", mem_we, m_owner >= 0 && we[o]);
    chk("rnd_mem_re", mem_re, m_owner >= 0 && re[o] && !we[o]);
    chk("rnd_mem_addr", mem_addr, (m_owner >= 0) ? addr[o] : m_addr_last);
    chk("rnd_mem_wdata", mem_wdata, (m_owner >= 0) ? wd[o] : m_wd_last);
    chk("rnd_rd_valid", rd_valid, m_rdv);
    chk("rnd_rdata", rdata, m_rdata);
    if (m_owner >= 0) chk("rnd_owner", owner, o);
`ifdef GB_ARB_STATS_EN
    chk("rnd_stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; we = '0; re = '0; mrd = '0; sclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      wd[i] = '0;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] req, lock, we, re, gnt, rdv;
    logic       mwe, mre;
  } vec_t;

  vec_t vecs [14];
  logic [3:0] starve_exp [10];

  initial begin
    vecs[0]  = '{4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b1010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1};
    vecs[5]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vecs[9]  = '{4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    starve_exp = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0100};

    // Reset state, observed while reset is held.
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rd_valid", rd_valid, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_owner", owner, 2'd0);
    chk("rst_busy", busy, 1'b0);
`ifdef GB_ARB_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 16'h0000);
`endif
    @(negedge clk);
    do_reset();

    // Priority, turnaround, write-over-read, UART preemption under lock.
    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req; lock = vecs[i].lock; we = vecs[i].we; re = vecs[i].re;
      #1;
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_busy", i), busy, |vecs[i].gnt);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].mwe);
      chk($sformatf("vec%0d_mem_re", i), mem_re, vecs[i].mre);
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].rdv);
      step();
    end

    // CPU-only read with registered return.
    do_reset();
    req = 4'b1000; re = 4'b1000; addr[3] = 16'hC000; mrd = 8'h5A;
    #1 chk("cpu_rd_latency0", gnt, 4'b0000);
    step();
    #1;
    chk("cpu_rd_gnt", gnt, 4'b1000);
    chk("cpu_rd_mem_re", mem_re, 1'b1);
    chk("cpu_rd_mem_addr", mem_addr, 16'hC000);
    step();
    req = 4'b0000; re = 4'b0000; mrd = 8'h00;
    #1;
    chk("cpu_rd_valid", rd_valid, 4'b1000);
    chk("cpu_rd_rdata", rdata, 8'h5A);
    step();
    #1;
    chk("cpu_rd_valid_pulse", rd_valid, 4'b0000);
    chk("cpu_rd_turn_addr", mem_addr, 16'hC000);

    // Starvation guard: OAM DMA holds the bus under lock, CPU waits.
    do_reset();
    req = 4'b1100; lock = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("starve_c%0d_gnt", i), gnt, starve_exp[i]);
      step();
    end

    // Guard never fires against UART.
    do_reset();
    req = 4'b1001;
    step();
    for (int i = 0; i < 12; i++) begin
      #1 chk($sformatf("uart_hold_c%0d_gnt", i), gnt, 4'b0001);
      step();
    end

    // Async reset in the middle of a write with a read return pending.
    do_reset();
    req = 4'b1000; re = 4'b1000; addr[3] = 16'h1234; mrd = 8'hA5;
    step();
    step();
    re = 4'b0000; we = 4'b1000;
    #1;
    chk("arst_pre_we", mem_we, 1'b1);
    chk("arst_pre_rdv", rd_valid, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", mem_we, 1'b0);
    chk("arst_gnt", gnt, 4'b0000);
    chk("arst_rd_valid", rd_valid, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    step();
    #1 chk("arst_idle_busy", busy, 1'b0);
    req = 4'b1000;
    #1 chk("arst_idle_gnt", gnt, 4'b0000);
    step();
    #1 chk("arst_regrant", gnt, 4'b1000);

`ifdef GB_ARB_STATS_EN
    // Stall counter: 10 blocked cycles, synchronous clear, saturation.
    do_reset();
    req = 4'b1001;
    repeat (10) step();
    req = 4'b0000;
    #1 chk("stall_10", stall_cnt, 16'd10);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    #1 chk("stall_clr", stall_cnt, 16'd0);
    req = 4'b1001;
    repeat (70000) @(negedge clk);
    #1 chk("stall_sat", stall_cnt, 16'hFFFF);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
        if ($urandom_range(5) == 0) lock[i] = ~lock[i];
        addr[i] = 16'($urandom);
        wd[i] = 8'($urandom);
      end
      we = 4'($urandom) & 4'($urandom);
      re = 4'($urandom);
      mrd = 8'($urandom);
      sclr = ($urandom_range(199) == 0);
      #1 check_model();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
